// File: rtl/clock_time_counter.sv
// Time-of-day counter for the digital clock.
// Keeps BCD hours/minutes/seconds, advances on the one-second tick and offers a
// small set mode (hours, then minutes) driven by debounced button pulses.
module clock_time_counter #(
    parameter int unsigned MAX_HOUR = 23  // last hour before wrap to 00, legal 1..23
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic [1:0] mode,
    output logic       day_pulse
);

    // Mode encoding is visible on the mode output, so it is fixed here.
    localparam logic [1:0] MODE_RUN      = 2'b00;
    localparam logic [1:0] MODE_SET_HOUR = 2'b01;
    localparam logic [1:0] MODE_SET_MIN  = 2'b10;

    // Last legal value of each field, in BCD.
    localparam logic [7:0] SEC_LAST  = 8'h59;
    localparam logic [7:0] MIN_LAST  = 8'h59;
    localparam logic [7:0] HOUR_LAST = {4'(MAX_HOUR / 10), 4'(MAX_HOUR % 10)};

    // Two-digit BCD increment that wraps to 00 after the given last value.
    function automatic logic [7:0] bcd_next(input logic [7:0] value, input logic [7:0] last);
        logic [7:0] result;
        if (value == last) begin
            result = 8'h00;
        end else if (value[3:0] >= 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hour_q, hour_d;
    logic [1:0] mode_q, mode_d;
    logic       day_q, day_d;

    // Incremented values and wrap flags for each field.
    logic [7:0] sec_inc, min_inc, hour_inc;
    logic       sec_wrap, min_wrap, hour_wrap;

    // Per-field increment candidates, shared by run and set modes.
    always_comb begin
        sec_inc   = bcd_next(sec_q, SEC_LAST);
        min_inc   = bcd_next(min_q, MIN_LAST);
        hour_inc  = bcd_next(hour_q, HOUR_LAST);
        sec_wrap  = (sec_q == SEC_LAST);
        min_wrap  = (min_q == MIN_LAST);
        hour_wrap = (hour_q == HOUR_LAST);
    end

    // Next-state for mode FSM and time fields.
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        mode_d = mode_q;
        day_d  = 1'b0;

        case (mode_q)
            MODE_RUN: begin
                // A tick coinciding with mode_btn still lands before entering set mode.
                if (tick) begin
                    sec_d = sec_inc;
                    if (sec_wrap) begin
                        min_d = min_inc;
                        if (min_wrap) begin
                            hour_d = hour_inc;
                            day_d  = hour_wrap;
                        end
                    end
                end
                if (mode_btn) begin
                    mode_d = MODE_SET_HOUR;
                end
            end

            MODE_SET_HOUR: begin
                // Time is frozen; mode_btn takes priority over inc_btn.
                if (mode_btn) begin
                    mode_d = MODE_SET_MIN;
                end else if (inc_btn) begin
                    hour_d = hour_inc;
                end
            end

            MODE_SET_MIN: begin
                if (mode_btn) begin
                    mode_d = MODE_RUN;
                    sec_d  = 8'h00;  // restart the minute cleanly when leaving set mode
                end else if (inc_btn) begin
                    min_d = min_inc;  // no carry into hours while setting
                end
            end

            default: begin
                // Unused encoding 11: fall back to run without touching time.
                mode_d = MODE_RUN;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sec_q  <= 8'h00;
            min_q  <= 8'h00;
            hour_q <= 8'h00;
            mode_q <= MODE_RUN;
            day_q  <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            mode_q <= mode_d;
            day_q  <= day_d;
        end
    end

    assign sec_bcd   = sec_q;
    assign min_bcd   = min_q;
    assign hour_bcd  = hour_q;
    assign mode      = mode_q;
    assign day_pulse = day_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench for clock_time_counter against a time-of-day model.
module tb_clock_time_counter;

    localparam int MAX_HOUR = 23;

    logic       clk;
    logic       clr;
    logic       tick;
    logic       mode_btn;
    logic       inc_btn;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic [1:0] mode;
    logic       day_pulse;

    clock_time_counter #(
        .MAX_HOUR(MAX_HOUR)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .tick     (tick),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .sec_bcd  (sec_bcd),
        .min_bcd  (min_bcd),
        .hour_bcd (hour_bcd),
        .mode     (mode),
        .day_pulse(day_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain integers for time and mode number.
    int m_h, m_m, m_s, m_mode;
    bit m_day;

    logic [26:0] obs;
    assign obs = {hour_bcd, min_bcd, sec_bcd, mode, day_pulse};

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function logic [26:0] exp_vec();
        return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), 2'(m_mode), m_day};
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_day = 0;
    endtask

    task automatic model_step(input bit t, input bit m, input bit i);
        int tod;
        m_day = 0;
        case (m_mode)
            0: begin
                if (t) begin
                    tod = (m_h * 3600 + m_m * 60 + m_s + 1) % ((MAX_HOUR + 1) * 3600);
                    m_day = (tod == 0);
                    m_h = tod / 3600;
                    m_m = (tod / 60) % 60;
                    m_s = tod % 60;
                end
                if (m) m_mode = 1;
            end
            1: begin
                if (m) m_mode = 2;
                else if (i) m_h = (m_h + 1) % (MAX_HOUR + 1);
            end
            default: begin
                if (m) begin
                    m_mode = 0;
                    m_s = 0;
                end else if (i) begin
                    m_m = (m_m + 1) % 60;
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs; called 1 time unit after a rising edge, returns likewise.
    task automatic cyc(input bit t, input bit m, input bit i);
        tick = t; mode_btn = m; inc_btn = i;
        @(posedge clk);
        #1;
        tick = 0; mode_btn = 0; inc_btn = 0;
        model_step(t, m, i);
    endtask

    task automatic apply_reset();
        clr = 1'b1;
        #2;
        clr = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        clr = 1'b1; tick = 0; mode_btn = 0; inc_btn = 0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
        n_cmp++;
        if (obs !== 27'h0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", obs, 27'h0);
        end
        for (int k = 0; k < 7; k++) cyc(1, 0, 0);
        cyc(0, 1, 0);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL pre_async_reset: got %h want %h", obs, exp_vec());
        end
        // Assert clear between edges and look before any clock edge arrives.
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== 27'h0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want %h", obs, 27'h0);
        end
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_carry_chain();
        apply_reset();
        for (int k = 0; k < 9; k++) cyc(1, 0, 0);
        n_cmp++;
        if (sec_bcd !== 8'h09) begin
            n_bad++;
            $display("FAIL carry_sec09: got %h want %h", sec_bcd, 8'h09);
        end
        cyc(1, 0, 0);
        n_cmp++;
        if (sec_bcd !== 8'h10) begin
            n_bad++;
            $display("FAIL carry_sec10: got %h want %h", sec_bcd, 8'h10);
        end
        for (int k = 0; k < 50; k++) begin
            cyc(1, 0, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL carry_step%0d: got %h want %h", k, obs, exp_vec());
            end
        end
        n_cmp++;
        if ({min_bcd, sec_bcd} !== 16'h0100) begin
            n_bad++;
            $display("FAIL carry_min01: got %h want %h", {min_bcd, sec_bcd}, 16'h0100);
        end
    endtask

    task automatic test_set_and_day_wrap();
        apply_reset();
        cyc(0, 1, 0);
        for (int k = 0; k < 23; k++) cyc(0, 0, 1);
        n_cmp++;
        if (hour_bcd !== 8'h23 || mode !== 2'b01) begin
            n_bad++;
            $display("FAIL set_hour23: got %h/%b want 23/01", hour_bcd, mode);
        end
        cyc(0, 1, 0);
        for (int k = 0; k < 59; k++) cyc(0, 0, 1);
        n_cmp++;
        if (min_bcd !== 8'h59 || hour_bcd !== 8'h23) begin
            n_bad++;
            $display("FAIL set_min59: got %h:%h want 23:59", hour_bcd, min_bcd);
        end
        cyc(0, 1, 0);
        n_cmp++;
        if (obs !== exp_vec() || sec_bcd !== 8'h00 || mode !== 2'b00) begin
            n_bad++;
            $display("FAIL set_exit_run: got %h want %h", obs, exp_vec());
        end
        for (int k = 0; k < 62; k++) begin
            cyc(1, 0, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL day_wrap_step%0d: got %h want %h", k, obs, exp_vec());
            end
            if (k == 59) begin
                n_cmp++;
                if (obs !== {24'h000000, 2'b00, 1'b1}) begin
                    n_bad++;
                    $display("FAIL day_pulse_at_wrap: got %h want %h", obs, 27'h1);
                end
            end
        end
    endtask

    task automatic test_set_wrap_freeze();
        apply_reset();
        for (int k = 0; k < 3; k++) cyc(1, 0, 0);
        cyc(0, 1, 0);
        for (int k = 0; k < 24; k++) begin
            cyc(k % 5 == 0, 0, 1);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL set_hour_wrap%0d: got %h want %h", k, obs, exp_vec());
            end
        end
        for (int k = 0; k < 5; k++) cyc(1, 0, 0);
        n_cmp++;
        if ({hour_bcd, min_bcd, sec_bcd, day_pulse} !== {24'h000003, 1'b0}) begin
            n_bad++;
            $display("FAIL set_freeze: got %h want %h", {hour_bcd, min_bcd, sec_bcd},
                     24'h000003);
        end
    endtask

    task automatic test_simultaneity();
        apply_reset();
        cyc(0, 1, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 1);
        cyc(0, 1, 1);
        n_cmp++;
        if (mode !== 2'b10 || hour_bcd !== 8'h05) begin
            n_bad++;
            $display("FAIL mode_inc_same: got %b/%h want 10/05", mode, hour_bcd);
        end
        cyc(1, 0, 1);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL tick_inc_same: got %h want %h", obs, exp_vec());
        end
        apply_reset();
        for (int k = 0; k < 59; k++) cyc(1, 0, 0);
        cyc(1, 1, 0);
        n_cmp++;
        if ({hour_bcd, min_bcd, sec_bcd, mode} !== {24'h000100, 2'b01}) begin
            n_bad++;
            $display("FAIL tick_mode_same: got %h/%b want 000100/01",
                     {hour_bcd, min_bcd, sec_bcd}, mode);
        end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        for (int k = 0; k < 30; k++) cyc(0, 0, 1);
        n_cmp++;
        if (min_bcd !== 8'h30 || mode !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_setup: got %h/%b want 30/10", min_bcd, mode);
        end
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== 27'h0) begin
            n_bad++;
            $display("FAIL mid_reset: got %h want %h", obs, 27'h0);
        end
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0);
        n_cmp++;
        if (sec_bcd !== 8'h01 || mode !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_first_tick: got %h/%b want 01/00", sec_bcd, mode);
        end
    endtask

    task automatic test_random();
        bit t, m, i;
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            t = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 40) == 0);
            i = ($urandom_range(0, 2) == 0);
            cyc(t, m, i);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %h want %h", k, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_set_and_day_wrap();
        test_set_wrap_freeze();
        test_simultaneity();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
